// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and default widths for the cache-to-memory block arbiter.
//   - state_e  : arbiter FSM encoding (IDLE / XFER / DONE)
//   - owner_e  : which cache holds the grant (OWN_I / OWN_D)
//   - pick_owner: round-robin grant selection between the two caches
package mem_arbiter_pkg;

  localparam int BLK_ADDR_W_DEF = 28;  // block address = byte address [31:4]
  localparam int WORDS_DEF      = 4;   // words per block, power of two
  localparam int WORD_W_DEF     = 32;  // main-memory word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // On a tie the port that did not finish the previous block wins. Because
  // last_owner resets to OWN_I, the D-cache wins the first tie after reset.
  function automatic owner_e pick_owner(input logic   pend_i,
                                        input logic   pend_d,
                                        input owner_e last_owner);
    owner_e gnt;
    if (pend_i && pend_d) begin
      gnt = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (pend_d) begin
      gnt = OWN_D;
    end else begin
      gnt = OWN_I;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// mem_beat_seq
//   Serialises one block transfer into WORDS word-wide memory beats.
//   Holds the beat counter, latched block address and op, the write buffer
//   (block to be written) and the read buffer (words returned by memory).
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            load a new transaction (addr/op/wdata), beat := 0
//   op_wr_i            1 = block write, 0 = block read (sampled on start_i)
//   blk_addr_i         block address (sampled on start_i)
//   wdata_i            write block, word k at [32k+31:32k] (sampled on start_i)
//   active_i           arbiter is in XFER; enables the memory strobes
//   mem_readdata_i     read data for the current beat
//   mem_busywait_i     memory stall; holds the current beat
//   mem_read_o         word read strobe
//   mem_write_o        word write strobe
//   mem_address_o      word address {blk_addr, beat}
//   mem_writedata_o    write-buffer word for the current beat
//   op_wr_o            latched op of the current transaction
//   last_done_o        final beat of the block completes this cycle
//   rblk_nxt_o         read buffer as it will be after this edge
module mem_beat_seq
  import mem_arbiter_pkg::*;
#(
  parameter  int BLK_ADDR_W = BLK_ADDR_W_DEF,
  parameter  int WORDS      = WORDS_DEF,
  parameter  int WORD_W     = WORD_W_DEF,
  localparam int BEAT_W     = $clog2(WORDS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         op_wr_i,
  input  logic [BLK_ADDR_W-1:0]        blk_addr_i,
  input  logic [WORDS*WORD_W-1:0]      wdata_i,
  input  logic                         active_i,
  input  logic [WORD_W-1:0]            mem_readdata_i,
  input  logic                         mem_busywait_i,
  output logic                         mem_read_o,
  output logic                         mem_write_o,
  output logic [BLK_ADDR_W+BEAT_W-1:0] mem_address_o,
  output logic [WORD_W-1:0]            mem_writedata_o,
  output logic                         op_wr_o,
  output logic                         last_done_o,
  output logic [WORDS*WORD_W-1:0]      rblk_nxt_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  logic [BEAT_W-1:0]                beat_q, beat_d;
  logic [BLK_ADDR_W-1:0]            blk_addr_q, blk_addr_d;
  logic                             op_wr_q, op_wr_d;
  logic [WORDS-1:0][WORD_W-1:0]     wbuf_q, wbuf_d;
  logic [WORDS-1:0][WORD_W-1:0]     rbuf_q, rbuf_d;
  logic                             beat_done;

  assign mem_read_o      = active_i & ~op_wr_q;
  assign mem_write_o     = active_i &  op_wr_q;
  assign mem_address_o   = {blk_addr_q, beat_q};
  assign mem_writedata_o = wbuf_q[beat_q];
  assign op_wr_o         = op_wr_q;

  // A stalled beat leaves beat_q, and therefore address and data, untouched.
  assign beat_done   = (mem_read_o | mem_write_o) & ~mem_busywait_i;
  assign last_done_o = beat_done & (beat_q == LAST_BEAT);
  assign rblk_nxt_o  = rbuf_d;

  always_comb begin
    beat_d     = beat_q;
    blk_addr_d = blk_addr_q;
    op_wr_d    = op_wr_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    if (start_i) begin
      beat_d     = '0;
      blk_addr_d = blk_addr_i;
      op_wr_d    = op_wr_i;
      wbuf_d     = wdata_i;
    end else if (beat_done) begin
      if (!op_wr_q) begin
        rbuf_d[beat_q] = mem_readdata_i;
      end
      // Modulo-WORDS count; the block address is never carried into.
      beat_d = beat_q + BEAT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      blk_addr_q <= '0;
      op_wr_q    <= 1'b0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
    end else begin
      beat_q     <= beat_d;
      blk_addr_q <= blk_addr_d;
      op_wr_q    <= op_wr_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates block refills (I-cache, read only) and block refills or
//   writebacks (D-cache) onto a single word-wide main-memory port. One cache
//   is served at a time; ties go round-robin. Each block moves as WORDS beats
//   through mem_beat_seq; the returned block is then presented to its cache
//   for one DONE cycle while that cache's busywait drops.
//
// Ports
//   CLK, RESET                 clock, synchronous active-low reset
//   I_READ, I_ADDRESS          I-cache block read request and address
//   I_READDATA, I_BUSYWAIT     block returned to I-cache, I-side stall
//   D_READ, D_WRITE            D-cache block read / writeback request
//   D_ADDRESS, D_WRITEDATA     D-cache block address and writeback block
//   D_READDATA, D_BUSYWAIT     block returned to D-cache, D-side stall
//   MEM_READ, MEM_WRITE        word strobes to main memory
//   MEM_ADDRESS                word address {blk_addr, beat}
//   MEM_WRITEDATA              beat write data
//   MEM_READDATA, MEM_BUSYWAIT beat read data, memory stall
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; grant a pending cache and latch its request
// XFER  | issue beats to memory until the last beat completes
// DONE  | one cycle: owner's busywait low, owner's READDATA valid
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int BLK_ADDR_W = BLK_ADDR_W_DEF,
  parameter  int WORDS      = WORDS_DEF,
  parameter  int WORD_W     = WORD_W_DEF,
  localparam int BEAT_W     = $clog2(WORDS)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         I_READ,
  input  logic [BLK_ADDR_W-1:0]        I_ADDRESS,
  output logic [WORDS*WORD_W-1:0]      I_READDATA,
  output logic                         I_BUSYWAIT,
  input  logic                         D_READ,
  input  logic                         D_WRITE,
  input  logic [BLK_ADDR_W-1:0]        D_ADDRESS,
  input  logic [WORDS*WORD_W-1:0]      D_WRITEDATA,
  output logic [WORDS*WORD_W-1:0]      D_READDATA,
  output logic                         D_BUSYWAIT,
  output logic                         MEM_READ,
  output logic                         MEM_WRITE,
  output logic [BLK_ADDR_W+BEAT_W-1:0] MEM_ADDRESS,
  output logic [WORD_W-1:0]            MEM_WRITEDATA,
  input  logic [WORD_W-1:0]            MEM_READDATA,
  input  logic                         MEM_BUSYWAIT
);

  state_e                    state_q, state_d;
  owner_e                    owner_q, owner_d;
  owner_e                    last_owner_q, last_owner_d;
  logic [WORDS*WORD_W-1:0]   i_rdata_q, i_rdata_d;
  logic [WORDS*WORD_W-1:0]   d_rdata_q, d_rdata_d;

  logic                      pend_i, pend_d;
  owner_e                    gnt_owner;
  logic                      start;
  logic                      start_wr;
  logic [BLK_ADDR_W-1:0]     start_addr;
  logic                      xfer_active;
  logic                      seq_op_wr;
  logic                      seq_last_done;
  logic [WORDS*WORD_W-1:0]   seq_rblk_nxt;

  assign pend_i = I_READ;
  assign pend_d = D_READ | D_WRITE;

  // Grant decision is only acted on in IDLE. A D request with both READ and
  // WRITE high is served as a writeback.
  assign gnt_owner  = pick_owner(pend_i, pend_d, last_owner_q);
  assign start      = (state_q == ST_IDLE) & (pend_i | pend_d);
  assign start_wr   = (gnt_owner == OWN_D) & D_WRITE;
  assign start_addr = (gnt_owner == OWN_D) ? D_ADDRESS : I_ADDRESS;

  mem_beat_seq #(
    .BLK_ADDR_W (BLK_ADDR_W),
    .WORDS      (WORDS),
    .WORD_W     (WORD_W)
  ) u_beat_seq (
    .clk_i           (CLK),
    .rst_ni          (RESET),
    .start_i         (start),
    .op_wr_i         (start_wr),
    .blk_addr_i      (start_addr),
    .wdata_i         (D_WRITEDATA),
    .active_i        (xfer_active),
    .mem_readdata_i  (MEM_READDATA),
    .mem_busywait_i  (MEM_BUSYWAIT),
    .mem_read_o      (MEM_READ),
    .mem_write_o     (MEM_WRITE),
    .mem_address_o   (MEM_ADDRESS),
    .mem_writedata_o (MEM_WRITEDATA),
    .op_wr_o         (seq_op_wr),
    .last_done_o     (seq_last_done),
    .rblk_nxt_o      (seq_rblk_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_i || pend_d) begin
          state_d = ST_XFER;
          owner_d = gnt_owner;
        end
      end
      ST_XFER: begin
        if (seq_last_done) begin
          state_d      = ST_DONE;
          last_owner_d = owner_q;
          // Load the owner's return register on the edge into DONE so the
          // whole block, including the final beat, is valid during DONE.
          if (!seq_op_wr) begin
            if (owner_q == OWN_I) begin
              i_rdata_d = seq_rblk_nxt;
            end else begin
              d_rdata_d = seq_rblk_nxt;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    xfer_active = (state_q == ST_XFER);
    I_BUSYWAIT  = pend_i & ~((state_q == ST_DONE) & (owner_q == OWN_I));
    D_BUSYWAIT  = pend_d & ~((state_q == ST_DONE) & (owner_q == OWN_D));
    I_READDATA  = i_rdata_q;
    D_READDATA  = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         I_READ = 1'b0;
  logic [27:0]  I_ADDRESS = '0;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ = 1'b0;
  logic         D_WRITE = 1'b0;
  logic [27:0]  D_ADDRESS = '0;
  logic [127:0] D_WRITEDATA = '0;
  logic [127:0] D_READDATA;
  logic         D_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [29:0]  MEM_ADDRESS;
  logic [31:0]  MEM_WRITEDATA;
  logic [31:0]  MEM_READDATA;
  logic         MEM_BUSYWAIT = 1'b0;

  mem_arbiter dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory content: word at address A reads back as A ^ 0xA5A50000.
  assign MEM_READDATA = {2'b00, MEM_ADDRESS} ^ 32'hA5A5_0000;

  typedef struct {
    logic         rst, ir, dr, dw, mb;
    logic [27:0]  ia, da;
    logic [127:0] wd;
    logic         e_ib, e_db, e_mr, e_mw, c_adr;
    logic [29:0]  e_adr;
    logic [31:0]  e_wd;
    logic [1:0]   c_rd;
    logic [127:0] e_ird, e_drd;
  } vec_t;

  vec_t         tbl[$];
  logic [27:0]  cur_ia;
  logic [27:0]  cur_da;
  logic [127:0] cur_wd;
  int           checks = 0;
  int           errors = 0;
  int           cur_row = -1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, cur_row, act, exp);
    end
  endtask

  // Row with no strobe expected. f = {rst, i_read, d_read, d_write, e_ibusy, e_dbusy}
  task automatic nrow(input logic [5:0] f);
    vec_t v;
    v.rst = f[5]; v.ir = f[4]; v.dr = f[3]; v.dw = f[2]; v.mb = 1'b0;
    v.ia = cur_ia; v.da = cur_da; v.wd = cur_wd;
    v.e_ib = f[1]; v.e_db = f[0]; v.e_mr = 1'b0; v.e_mw = 1'b0;
    v.c_adr = 1'b0; v.e_adr = '0; v.e_wd = '0;
    v.c_rd = 2'b00; v.e_ird = '0; v.e_drd = '0;
    tbl.push_back(v);
  endtask

  // Transfer row. f = {i_read, d_read, d_write, mem_busy, e_ibusy, e_dbusy, e_mread, e_mwrite}
  task automatic srow(input logic [7:0] f, input logic [29:0] adr, input logic [31:0] wd);
    vec_t v;
    v.rst = 1'b1; v.ir = f[7]; v.dr = f[6]; v.dw = f[5]; v.mb = f[4];
    v.ia = cur_ia; v.da = cur_da; v.wd = cur_wd;
    v.e_ib = f[3]; v.e_db = f[2]; v.e_mr = f[1]; v.e_mw = f[0];
    v.c_adr = 1'b1; v.e_adr = adr; v.e_wd = wd;
    v.c_rd = 2'b00; v.e_ird = '0; v.e_drd = '0;
    tbl.push_back(v);
  endtask

  task automatic rd_i(input logic [127:0] val);
    vec_t v;
    v = tbl.pop_back();
    v.c_rd[0] = 1'b1;
    v.e_ird = val;
    tbl.push_back(v);
  endtask

  task automatic rd_d(input logic [127:0] val);
    vec_t v;
    v = tbl.pop_back();
    v.c_rd[1] = 1'b1;
    v.e_drd = val;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // I-cache read of block 0x10, zero-wait memory.
    cur_ia = 28'h10; cur_da = 28'h0; cur_wd = '0;
    nrow(6'b1_1_0_0_1_0);
    srow(8'b1_0_0_0_1_0_1_0, 30'h40, 32'h0);
    srow(8'b1_0_0_0_1_0_1_0, 30'h41, 32'h0);
    srow(8'b1_0_0_0_1_0_1_0, 30'h42, 32'h0);
    srow(8'b1_0_0_0_1_0_1_0, 30'h43, 32'h0);
    nrow(6'b1_1_0_0_0_0); rd_i(128'hA5A50043_A5A50042_A5A50041_A5A50040);
    nrow(6'b1_0_0_0_0_0);
    // D-cache writeback of block 0x2.
    cur_da = 28'h2; cur_wd = 128'hDDDDCCCC_BBBBAAAA_44443333_22221111;
    nrow(6'b1_0_0_1_0_1);
    srow(8'b0_0_1_0_0_1_0_1, 30'h08, 32'h22221111);
    srow(8'b0_0_1_0_0_1_0_1, 30'h09, 32'h44443333);
    srow(8'b0_0_1_0_0_1_0_1, 30'h0A, 32'hBBBBAAAA);
    srow(8'b0_0_1_0_0_1_0_1, 30'h0B, 32'hDDDDCCCC);
    nrow(6'b1_0_0_1_0_0);
    nrow(6'b1_0_0_0_0_0);
    // Reset, then simultaneous I and D reads: D wins the first tie.
    nrow(6'b0_0_0_0_0_0);
    cur_ia = 28'h11; cur_da = 28'h5;
    nrow(6'b1_1_1_0_1_1); rd_i(128'h0); rd_d(128'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h14, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h15, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h16, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h17, 32'h0);
    nrow(6'b1_1_1_0_1_0); rd_d(128'hA5A50017_A5A50016_A5A50015_A5A50014);
    // D raises a new read while I still waits: tie again, I wins now.
    cur_da = 28'h6;
    nrow(6'b1_1_1_0_1_1);
    srow(8'b1_1_0_0_1_1_1_0, 30'h44, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h45, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h46, 32'h0);
    srow(8'b1_1_0_0_1_1_1_0, 30'h47, 32'h0);
    nrow(6'b1_1_1_0_0_1); rd_i(128'hA5A50047_A5A50046_A5A50045_A5A50044);
    nrow(6'b1_0_1_0_0_1);
    srow(8'b0_1_0_0_0_1_1_0, 30'h18, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h19, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1A, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1B, 32'h0);
    nrow(6'b1_0_1_0_0_0); rd_d(128'hA5A5001B_A5A5001A_A5A50019_A5A50018);
    nrow(6'b1_0_0_0_0_0);
    // D read with memory stalled 3 cycles on beat 2: busywait high 8 cycles.
    cur_da = 28'h7;
    nrow(6'b1_0_1_0_0_1);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1C, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1D, 32'h0);
    srow(8'b0_1_0_1_0_1_1_0, 30'h1E, 32'h0);
    srow(8'b0_1_0_1_0_1_1_0, 30'h1E, 32'h0);
    srow(8'b0_1_0_1_0_1_1_0, 30'h1E, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1E, 32'h0);
    srow(8'b0_1_0_0_0_1_1_0, 30'h1F, 32'h0);
    nrow(6'b1_0_1_0_0_0); rd_d(128'hA5A5001F_A5A5001E_A5A5001D_A5A5001C);
    nrow(6'b1_0_0_0_0_0);
    // D_READ and D_WRITE together: served as a writeback.
    cur_da = 28'h3; cur_wd = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    nrow(6'b1_0_1_1_0_1);
    srow(8'b0_1_1_0_0_1_0_1, 30'h0C, 32'hCAFE0000);
    srow(8'b0_1_1_0_0_1_0_1, 30'h0D, 32'hCAFE0001);
    srow(8'b0_1_1_0_0_1_0_1, 30'h0E, 32'hCAFE0002);
    srow(8'b0_1_1_0_0_1_0_1, 30'h0F, 32'hCAFE0003);
    nrow(6'b1_0_1_1_0_0);
    nrow(6'b1_0_0_0_0_0);

    // Reset state.
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_ibusy", 128'(I_BUSYWAIT), 128'(1'b0));
    chk("reset_dbusy", 128'(D_BUSYWAIT), 128'(1'b0));
    chk("reset_mread", 128'(MEM_READ), 128'(1'b0));
    chk("reset_mwrite", 128'(MEM_WRITE), 128'(1'b0));
    chk("reset_irdata", I_READDATA, 128'h0);
    chk("reset_drdata", D_READDATA, 128'h0);

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge CLK);
      RESET        = tbl[n].rst;
      I_READ       = tbl[n].ir;
      I_ADDRESS    = tbl[n].ia;
      D_READ       = tbl[n].dr;
      D_WRITE      = tbl[n].dw;
      D_ADDRESS    = tbl[n].da;
      D_WRITEDATA  = tbl[n].wd;
      MEM_BUSYWAIT = tbl[n].mb;
      #1;
      cur_row = n;
      chk("i_busywait", 128'(I_BUSYWAIT), 128'(tbl[n].e_ib));
      chk("d_busywait", 128'(D_BUSYWAIT), 128'(tbl[n].e_db));
      chk("mem_read", 128'(MEM_READ), 128'(tbl[n].e_mr));
      chk("mem_write", 128'(MEM_WRITE), 128'(tbl[n].e_mw));
      if (tbl[n].c_adr) chk("mem_address", 128'(MEM_ADDRESS), 128'(tbl[n].e_adr));
      if (tbl[n].e_mw) chk("mem_writedata", 128'(MEM_WRITEDATA), 128'(tbl[n].e_wd));
      if (tbl[n].c_rd[0]) chk("i_readdata", I_READDATA, tbl[n].e_ird);
      if (tbl[n].c_rd[1]) chk("d_readdata", D_READDATA, tbl[n].e_drd);
    end

    // Reset during beat 1 of an I read of block 0x21; request stays high.
    cur_row = -1;
    @(negedge CLK);
    I_READ = 1'b1; I_ADDRESS = 28'h21;
    @(negedge CLK);
    #1;
    chk("rst_seq_beat0_read", 128'(MEM_READ), 128'(1'b1));
    chk("rst_seq_beat0_addr", 128'(MEM_ADDRESS), 128'(30'h84));
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_seq_beat1_addr", 128'(MEM_ADDRESS), 128'(30'h85));
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_seq_mread_low", 128'(MEM_READ), 128'(1'b0));
    chk("rst_seq_mwrite_low", 128'(MEM_WRITE), 128'(1'b0));
    chk("rst_seq_ibusy", 128'(I_BUSYWAIT), 128'(1'b1));
    chk("rst_seq_addr_clear", 128'(MEM_ADDRESS), 128'(30'h0));
    chk("rst_seq_irdata", I_READDATA, 128'h0);
    chk("rst_seq_drdata", D_READDATA, 128'h0);
    @(negedge CLK);
    #1;
    chk("restart_read", 128'(MEM_READ), 128'(1'b1));
    chk("restart_addr", 128'(MEM_ADDRESS), 128'(30'h84));
    begin
      int cyc;
      cyc = 0;
      while (I_BUSYWAIT && cyc < 20) begin
        @(negedge CLK);
        #1;
        cyc++;
      end
      chk("restart_done", 128'(I_BUSYWAIT), 128'(1'b0));
      chk("restart_latency", 128'(cyc), 128'(4));
    end
    chk("restart_irdata", I_READDATA, 128'hA5A50087_A5A50086_A5A50085_A5A50084);
    @(negedge CLK);
    I_READ = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
